// File: rtl/rv32i_dmem_responder.sv
// RV32I data-memory responder: serialised byte/half/word loads and stores
// against a word RAM, with configurable wait states before the response.
module rv32i_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam bit          HAS_WAIT = WAIT_CYCLES > 0;
    localparam logic [3:0]  CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  f3_q;
    logic [31:0] wdata_q;
    logic [31:0] hold_rdata;
    logic        hold_err;
    logic [31:0] mem [DEPTH_WORDS];

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [2:0]  cur_f3;
    logic [31:0] cur_wdata;
    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic        oob, illegal, misal, err;
    logic        enter_resp, wr_en;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] word;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [31:0] ld_data;

    // A zero-wait acceptance commits on the accept edge, so use live inputs.
    assign cur_we    = (state == S_IDLE) ? req_we     : we_q;
    assign cur_addr  = (state == S_IDLE) ? req_addr   : addr_q;
    assign cur_f3    = (state == S_IDLE) ? req_funct3 : f3_q;
    assign cur_wdata = (state == S_IDLE) ? req_wdata  : wdata_q;

    assign offset = cur_addr - BASE_ADDR;
    assign oob    = offset >= SPAN;
    assign idx    = offset[AW+1:2];
    assign lane   = offset[1:0];

    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        if (cur_we)
            illegal = cur_f3[2] || (cur_f3[1:0] == 2'b11);
        else
            illegal = (cur_f3[1:0] == 2'b11) || (cur_f3 == 3'b110);
        if (cur_f3[1:0] == 2'b01)
            misal = lane[0];
        else if (cur_f3[1:0] == 2'b10)
            misal = (lane != 2'b00);
        err = oob || illegal || misal;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid) state_nx = HAS_WAIT ? S_WAIT : S_RESP;
            S_WAIT: if (cnt == 4'd0) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign enter_resp = (state_nx == S_RESP);
    assign wr_en      = enter_resp && !rst && cur_we && !err;
    assign req_ready  = (state == S_IDLE);

    always_comb begin
        be = 4'b1111;
        wd = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign word = mem[idx];
    assign bsel = word[8*lane +: 8];
    assign hsel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_data = '0;
        case (cur_f3)
            3'b000:  ld_data = {{24{bsel[7]}}, bsel};
            3'b001:  ld_data = {{16{hsel[15]}}, hsel};
            3'b010:  ld_data = word;
            3'b100:  ld_data = {24'd0, bsel};
            3'b101:  ld_data = {16'd0, hsel};
            default: ld_data = '0;
        endcase
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            f3_q       <= '0;
            wdata_q    <= '0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
                cnt     <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                hold_err   <= err;
                hold_rdata <= (cur_we || err) ? 32'd0 : ld_data;
            end
            rsp_valid <= (state == S_RESP);
            rsp_rdata <= (state == S_RESP) ? hold_rdata : 32'd0;
            rsp_err   <= (state == S_RESP) && hold_err;
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: three instances with
// WAIT_CYCLES of 1, 3 and 0 sharing one clock.
module tb_rv32i_dmem_responder;

    localparam int ND = 3;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [ND];
    logic        req_valid  [ND];
    logic        req_ready  [ND];
    logic        req_we     [ND];
    logic [31:0] req_addr   [ND];
    logic [2:0]  req_funct3 [ND];
    logic [31:0] req_wdata  [ND];
    logic        rsp_valid  [ND];
    logic [31:0] rsp_rdata  [ND];
    logic        rsp_err    [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        rv32i_dmem_responder #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  (32'h0000_1000),
            .WAIT_CYCLES(WC)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_funct3(req_funct3[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    int n_chk  = 0;
    int n_pass = 0;
    int last_lat;
    int last_rlow;
    logic last_post;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic start(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wdat);
        @(negedge clk);
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wdat;
        req_valid[d]  = 1'b1;
        for (int i = 0; i < 40 && !req_ready[d]; i++) @(negedge clk);
        if (!req_ready[d]) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    task automatic finish(input int d, output logic [31:0] rd,
                          output logic er, output int lat, output int rlow,
                          output logic post);
        int j = 1;
        rlow = 0;
        while (!rsp_valid[d] && j < 40) begin
            if (!req_ready[d]) rlow++;
            @(negedge clk);
            j++;
        end
        if (!rsp_valid[d]) check("rsp_timeout", 32'd0, 32'd1);
        lat = j - 1;
        rd  = rsp_rdata[d];
        er  = rsp_err[d];
        @(negedge clk);
        post = rsp_valid[d] | (|rsp_rdata[d]) | rsp_err[d];
    endtask

    task automatic acc(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wdat,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        logic er;
        start(d, we, f3, a, wdat);
        finish(d, last_rd, er, last_lat, last_rlow, last_post);
        check({tag, "_rdata"}, last_rd, exp_rd);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic watch_no_rsp(input int d, input string tag);
        logic seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= rsp_valid[d];
        end
        check({tag, "_no_rsp"}, {31'd0, seen}, 32'd0);
        check({tag, "_ready"}, {31'd0, req_ready[d]}, 32'd1);
        check({tag, "_rdata0"}, rsp_rdata[d], 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        logic [7:0] pat;
        int bad;

        for (int d = 0; d < ND; d++) begin
            rst[d]        = 1'b1;
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = '0;
            req_funct3[d] = '0;
            req_wdata[d]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) rst[d] = 1'b0;
        check("rst_ready", {31'd0, req_ready[0]}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("rst_rdata", rsp_rdata[0], 32'd0);
        check("rst_err", {31'd0, rsp_err[0]}, 32'd0);
        check("rst_ready_w3", {31'd0, req_ready[1]}, 32'd1);
        check("rst_ready_w0", {31'd0, req_ready[2]}, 32'd1);

        // WAIT_CYCLES = 1
        acc(0, 1'b1, F_W, 32'h1000, 32'hDEAD_BEEF, 32'd0, 1'b0, "sw");
        check("sw_latency", last_lat, 32'd2);
        check("sw_ready_low", last_rlow, 32'd2);
        check("sw_one_cycle", {31'd0, last_post}, 32'd0);
        acc(0, 1'b0, F_W, 32'h1000, 32'd0, 32'hDEAD_BEEF, 1'b0, "lw");
        check("lw_latency", last_lat, 32'd2);
        check("lw_ready_low", last_rlow, 32'd2);
        check("lw_one_cycle", {31'd0, last_post}, 32'd0);

        acc(0, 1'b1, F_B, 32'h1003, 32'h1234_5680, 32'd0, 1'b0, "sb");
        acc(0, 1'b0, F_B, 32'h1003, 32'd0, 32'hFFFF_FF80, 1'b0, "lb");
        acc(0, 1'b0, F_BU, 32'h1003, 32'd0, 32'h0000_0080, 1'b0, "lbu");
        acc(0, 1'b0, F_W, 32'h1000, 32'd0, 32'h80AD_BEEF, 1'b0, "lw_sb");

        acc(0, 1'b1, F_H, 32'h1006, 32'hAAAA_8001, 32'd0, 1'b0, "sh");
        acc(0, 1'b0, F_H, 32'h1006, 32'd0, 32'hFFFF_8001, 1'b0, "lh");
        acc(0, 1'b0, F_HU, 32'h1006, 32'd0, 32'h0000_8001, 1'b0, "lhu");
        start(0, 1'b0, F_W, 32'h1004, 32'd0);
        finish(0, rd, er, last_lat, last_rlow, last_post);
        check("lw_sh_upper", {16'd0, rd[31:16]}, 32'h0000_8001);
        check("lw_sh_err", {31'd0, er}, 32'd0);

        acc(0, 1'b0, F_W, 32'h1002, 32'd0, 32'd0, 1'b1, "lw_misal");
        acc(0, 1'b0, F_H, 32'h1001, 32'd0, 32'd0, 1'b1, "lh_misal");
        acc(0, 1'b1, F_W, 32'h0FFC, 32'h5555_5555, 32'd0, 1'b1, "sw_below");
        acc(0, 1'b0, F_W, 32'h2000, 32'd0, 32'd0, 1'b1, "lw_past_end");
        acc(0, 1'b0, 3'b011, 32'h1000, 32'd0, 32'd0, 1'b1, "ld_f3_011");
        acc(0, 1'b0, 3'b110, 32'h1000, 32'd0, 32'd0, 1'b1, "ld_f3_110");
        acc(0, 1'b1, F_W, 32'h1002, 32'h1111_1111, 32'd0, 1'b1, "sw_misal");
        acc(0, 1'b1, 3'b011, 32'h1000, 32'h2222_2222, 32'd0, 1'b1, "st_f3_011");
        acc(0, 1'b1, F_W, 32'h2000, 32'h3333_3333, 32'd0, 1'b1, "sw_past_end");
        check("err_one_cycle", {31'd0, last_post}, 32'd0);
        acc(0, 1'b0, F_W, 32'h1000, 32'd0, 32'h80AD_BEEF, 1'b0, "lw_after_err");
        acc(0, 1'b1, F_W, 32'h1FFC, 32'hA5A5_A5A5, 32'd0, 1'b0, "sw_last");
        acc(0, 1'b0, F_W, 32'h1FFC, 32'd0, 32'hA5A5_A5A5, 1'b0, "lw_last");

        // WAIT_CYCLES = 3
        acc(1, 1'b1, F_W, 32'h1010, 32'd0, 32'd0, 1'b0, "w3_sw0");
        check("w3_latency", last_lat, 32'd4);
        check("w3_ready_low", last_rlow, 32'd4);
        start(1, 1'b1, F_W, 32'h1010, 32'h1234_5678);
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        watch_no_rsp(1, "rst_wait");
        acc(1, 1'b0, F_W, 32'h1010, 32'd0, 32'd0, 1'b0, "rst_wait_dropped");
        start(1, 1'b1, F_W, 32'h1010, 32'h1234_5678);
        repeat (3) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        watch_no_rsp(1, "rst_resp");
        acc(1, 1'b0, F_W, 32'h1010, 32'd0, 32'h1234_5678, 1'b0, "rst_resp_kept");

        // WAIT_CYCLES = 0
        acc(2, 1'b1, F_W, 32'h1000, 32'hCAFE_F00D, 32'd0, 1'b0, "w0_sw");
        check("w0_latency", last_lat, 32'd1);
        check("w0_ready_low", last_rlow, 32'd1);
        acc(2, 1'b0, F_B, 32'h1001, 32'd0, 32'hFFFF_FFF0, 1'b0, "w0_lb");

        @(negedge clk);
        req_we[2]     = 1'b0;
        req_funct3[2] = F_W;
        req_addr[2]   = 32'h1000;
        req_valid[2]  = 1'b1;
        @(posedge clk);
        pat = '0;
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            pat[j] = rsp_valid[2];
            if (rsp_valid[2] && rsp_rdata[2] !== 32'hCAFE_F00D) bad++;
        end
        req_valid[2] = 1'b0;
        check("b2b_pattern", {24'd0, pat}, 32'h0000_00AA);
        check("b2b_rdata", bad, 32'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
